pixel_enh_ctrl: RTL
===================

PIXEL_ENH_CTRL -- requirements
Module: pixel_enh_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 8, pixel width.
- IMG_W, 256, pixels per line.
- IMG_H, 256, lines per frame.
- ADDR_WIDTH, 16, frame memory address width; must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- start, in, 1, begin one frame; sampled in IDLE only.
- abort, in, 1, cancel the frame in progress.
- pause, in, 1, hold read issue; in-flight pixels continue.
- mode, in, 2, transform select: 00 bypass, 01 negative, 10 threshold, 11 treated as bypass.
- thresh, in, DATA_WIDTH, threshold level.
- rd_en, out, 1, source memory read strobe.
- rd_addr, out, ADDR_WIDTH, source memory read address.
- rd_data, in, DATA_WIDTH, source data, valid 1 cycle after rd_en.
- proc_valid, out, 1, pixel strobe to the negative-transform unit.
- proc_pixel, out, DATA_WIDTH, pixel sent to the transform unit.
- proc_result, in, DATA_WIDTH, transform unit output, valid 1 cycle after proc_valid.
- wr_en, out, 1, destination memory write strobe.
- wr_addr, out, ADDR_WIDTH, destination write address.
- wr_data, out, DATA_WIDTH, destination write data.
- busy, out, 1, high in RUN or DRAIN.
- done, out, 1, one-cycle pulse at frame completion.

Function
REQ-003 The FSM SHALL have four states with these transitions:
- IDLE to RUN on start.
- RUN to DRAIN after read N-1 is issued, where N = IMG_W*IMG_H.
- DRAIN to DONE when write N-1 is issued.
- DONE to IDLE unconditionally after one cycle.
REQ-004 mode and thresh SHALL be latched on the IDLE-to-RUN transition; later changes have no effect until the next frame.
REQ-005 In RUN with pause low, rd_en SHALL be high each cycle; rd_addr runs 0 to N-1 by +1.
REQ-006 pause high SHALL hold rd_en low and rd_addr frozen; pause has no effect outside RUN.
REQ-007 The pipeline timing SHALL be fixed for all modes:
- read issued at cycle t;
- proc_valid and proc_pixel (registered rd_data) at t+2;
- wr_en at t+4.
REQ-008 This gives first wr_en exactly 5 cycles after the cycle in which start is sampled, with no pause.
REQ-009 proc_valid SHALL be driven for every pixel in every mode; proc_result SHALL be used only in mode 01.
REQ-010 wr_data SHALL be selected by the latched mode:
- 00/11: raw pixel, delayed internally.
- 01: proc_result registered.
- 10: all ones if raw pixel >= thresh, else 0. The comparison is unsigned, so thresh=0 yields all ones for every pixel.
REQ-011 wr_addr SHALL start at 0 and increment by 1 after each write; exactly N writes per frame, in source order.
REQ-012 start SHALL be ignored when not in IDLE; start asserted together with abort in IDLE SHALL be ignored.
REQ-013 abort in RUN or DRAIN SHALL take effect as follows:
- next state IDLE, with no done pulse;
- all pipeline valids cleared;
- rd_en, proc_valid and wr_en low from the next cycle;
- counters reset to 0.
REQ-014 busy SHALL be high in RUN and DRAIN only; done SHALL be high only in DONE.
REQ-015 Address counters SHALL never wrap within a frame; the last rd_addr and last wr_addr are N-1.

Reset
REQ-016 While reset is low, the block SHALL be held as follows:
- state IDLE;
- all counters, pipeline valids, the latched mode and thresh, and every output at 0.
REQ-017 Reset assertion mid-frame SHALL abandon the frame immediately, without a done pulse.

Configuration
REQ-018 With macro PIXEL_ENH_CHECKSUM_EN defined, the block SHALL add the following:
- output checksum[15:0], the modulo-2^16 sum of all wr_data written this frame;
- checksum cleared on start acceptance;
- checksum stable from the done pulse until the next start.
REQ-019 Without PIXEL_ENH_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, each with the stated required response:
- IMG_W=4, IMG_H=2, mode 01, source 0..7: wr_data 255..248 at addr 0..7; first wr_en 5 cycles after start; done 1 cycle after the last write.
- mode 10, thresh=0x80, source 0x7F, 0x80, 0xFF, 0x00: wr_data 0x00, 0xFF, 0xFF, 0x00.
- pause high for 3 cycles after 2 reads: no gap in data order; 8 writes total; addresses contiguous; done still asserted once.
- abort asserted at the 3rd read: no further wr_en after in-flight clear; busy low next cycle; no done; a new start runs the full frame from addr 0.
- start pulsed in RUN, and mode changed mid-frame: both ignored; the frame completes in the original mode.
- With PIXEL_ENH_CHECKSUM_EN, mode 00, source 0xFF x 8: checksum = 0x07F8 at done.

Source files
------------

// File: rtl/pixel_enh_ctrl.sv
// pixel_enh_ctrl
//   Streams one frame of IMG_W*IMG_H pixels from a source memory, through a
//   fixed-latency enhancement pipeline, into a destination memory.
//
//   Pipeline (t = cycle in which a read is issued):
//     t    rd_en / rd_addr
//     t+1  rd_data returned by the source memory
//     t+2  proc_valid / proc_pixel (registered rd_data)
//     t+3  proc_result returned by the negative-transform unit
//     t+4  wr_en / wr_addr / wr_data
//   The latency is the same in every mode, so the write order always matches
//   the read order.
//
//   Modes (latched when a frame starts):
//     00/11 bypass, 01 negative (external unit), 10 threshold.
//
// Ports
//   clk, reset (async, active low)
//   start, abort, pause, mode[1:0], thresh       control inputs
//   rd_en, rd_addr, rd_data                      source memory port
//   proc_valid, proc_pixel, proc_result          transform unit port
//   wr_en, wr_addr, wr_data                      destination memory port
//   busy, done                                   status
//   checksum[15:0]                               only with PIXEL_ENH_CHECKSUM_EN
//
// Optional feature macro: PIXEL_ENH_CHECKSUM_EN
//   Adds a modulo-2^16 sum of all wr_data written in the current frame.

module pixel_enh_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  proc_valid,
  output logic [DATA_WIDTH-1:0] proc_pixel,
  input  logic [DATA_WIDTH-1:0] proc_result,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
`ifdef PIXEL_ENH_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] rd_cnt_reg;
  logic [ADDR_WIDTH-1:0] wr_cnt_reg;
  logic [1:0]            mode_reg;
  logic [DATA_WIDTH-1:0] thresh_reg;

  // Per-stage valid flags; stage k holds a pixel read k cycles ago.
  logic                  v1_reg, v2_reg, v3_reg, v4_reg;
  logic [DATA_WIDTH-1:0] pix2_reg;   // drives proc_pixel
  logic [DATA_WIDTH-1:0] pix3_reg;   // raw pixel aligned with proc_result
  logic [DATA_WIDTH-1:0] wdata_reg;

  logic start_ok;
  logic abort_ok;
  logic clear_cnt;

  // A start that arrives together with abort is dropped.
  assign start_ok  = (state_reg == S_IDLE) && start && !abort;
  assign abort_ok  = abort && ((state_reg == S_RUN) || (state_reg == S_DRAIN));
  // Counters sit at zero whenever no frame is in progress.
  assign clear_cnt = abort_ok || (state_reg == S_IDLE) || (state_reg == S_DONE);

  assign rd_addr    = rd_cnt_reg;
  assign wr_addr    = wr_cnt_reg;
  assign proc_valid = v2_reg;
  assign proc_pixel = pix2_reg;
  assign wr_en      = v4_reg;
  assign wr_data    = wdata_reg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start_ok) state_next = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        rd_en = !pause;
        if (abort) begin
          state_next = S_IDLE;
        end else if (!pause && (rd_cnt_reg == LAST_ADDR)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          state_next = S_IDLE;
        end else if (v4_reg && (wr_cnt_reg == LAST_ADDR)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ frame settings
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg   <= 2'b00;
      thresh_reg <= '0;
    end else if (start_ok) begin
      mode_reg   <= mode;
      thresh_reg <= thresh;
    end
  end

  // ------------------------------------------------------------ counters
  // Counters saturate at the last address so they can never wrap in a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else if (clear_cnt) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      if (rd_en && (rd_cnt_reg != LAST_ADDR)) rd_cnt_reg <= rd_cnt_reg + 1'b1;
      if (v4_reg && (wr_cnt_reg != LAST_ADDR)) wr_cnt_reg <= wr_cnt_reg + 1'b1;
    end
  end

  // ------------------------------------------------------------ pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
      v4_reg <= 1'b0;
    end else if (abort_ok) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
      v4_reg <= 1'b0;
    end else begin
      v1_reg <= rd_en;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
      v4_reg <= v3_reg;
    end
  end

  // Data registers only load on a valid stage so stale or unknown memory
  // outputs never reach the ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix2_reg  <= '0;
      pix3_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      if (v1_reg) pix2_reg <= rd_data;
      if (v2_reg) pix3_reg <= pix2_reg;
      if (v3_reg) begin
        case (mode_reg)
          2'b01:   wdata_reg <= proc_result;
          2'b10:   wdata_reg <= (pix3_reg >= thresh_reg) ? {DATA_WIDTH{1'b1}}
                                                         : {DATA_WIDTH{1'b0}};
          default: wdata_reg <= pix3_reg;
        endcase
      end
    end
  end

`ifdef PIXEL_ENH_CHECKSUM_EN
  // ------------------------------------------------------------ checksum
  // Cleared when a frame is accepted; no writes occur after done, so the
  // value stays put until the next accepted start.
  logic [15:0] checksum_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_reg <= 16'd0;
    end else if (start_ok) begin
      checksum_reg <= 16'd0;
    end else if (v4_reg) begin
      checksum_reg <= checksum_reg + 16'(wdata_reg);
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule
